dac_spi_serializer: RTL and testbench
=====================================

# dac_spi_serializer

Serial DAC output stage that sits directly downstream of the sine NCO. It accepts one parallel DATA_W-bit sample per sample strobe (the NCO's `enable_out`/`q` pair) and shifts it MSB-first to an external SPI DAC. It then pulses LDAC so the converter updates once per sample period. A one-entry holding register absorbs a strobe that arrives mid-frame, and a sticky flag reports overruns.

## Interface
Parameters:
- DATA_W, 24, sample width and number of bits per SPI frame.
- SCLK_HALF, 8, clk cycles per SCLK half-period; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- sample_valid  in  1  one-cycle strobe; sample_in is valid this cycle.
- sample_in  in  DATA_W  two's-complement sample.
- overrun_clr  in  1  clears the overrun flag.
- sclk  out  1  SPI clock, idle low.
- sync_n  out  1  frame select, active low.
- sdo  out  1  serial data, MSB first.
- ldac_n  out  1  DAC load strobe, active low.
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; a sample was dropped.

## Operation
- All outputs are registered. Reset values: sclk=0, sync_n=1, sdo=0, ldac_n=1, busy=0, overrun=0. Reset also clears the holding register and forces the FSM to IDLE.
- Holding register (hold_data, hold_valid):
  - When sample_valid=1 and hold_valid=0, capture sample_in and set hold_valid.
  - When sample_valid=1, hold_valid=1, and the FSM is consuming the hold entry this same cycle, the new sample replaces it and hold_valid stays 1. No overrun is flagged.
  - When sample_valid=1, hold_valid=1, and the entry is not being consumed, discard the new sample, keep the older one, and set overrun.
- overrun is cleared by overrun_clr. If overrun_clr and a new overrun event occur in the same cycle, the set wins.
- FSM states: IDLE → LEAD → SHIFT → TRAIL → LOAD → IDLE.
  - IDLE: when hold_valid=1, load the shift register from hold_data, clear hold_valid, and go to LEAD.
  - LEAD: sync_n=0, sclk=0, sdo=bit DATA_W-1. Lasts SCLK_HALF cycles.
  - SHIFT: DATA_W SCLK periods; each period is SCLK_HALF cycles high, then SCLK_HALF cycles low.
    - The DAC samples sdo on the sclk rising edge.
    - sdo advances to the next bit on the sclk falling edge.
    - After the last low phase, go to TRAIL.
  - TRAIL: sync_n=1, sclk=0, sdo=0. Lasts SCLK_HALF cycles.
  - LOAD: ldac_n=0. Lasts SCLK_HALF cycles, then go to IDLE.
- A single phase counter of width clog2(SCLK_HALF) and a bit counter of width clog2(DATA_W+1) are sufficient. Counters reset to 0 on every state entry.
- A frame occupies (2·DATA_W+3)·SCLK_HALF cycles: 408 at the defaults. This is below the 1041-cycle sample period, so steady-state operation never overruns.

## Timing
- sample_valid is sampled at edge N and lands in the hold register. At edge N+1 the FSM (if IDLE) enters LEAD, so sync_n is low from edge N+1.
- First sclk rising edge: N+1+SCLK_HALF.
- ldac_n falls at N+1+(2·DATA_W+2)·SCLK_HALF and rises SCLK_HALF cycles later. busy falls on the same edge that ldac_n rises.
- A strobe arriving while busy is served in the IDLE cycle following LOAD. Its sync_n falls 1 cycle after busy falls.
- Reset mid-frame aborts immediately: all outputs take their reset values on the next edge, and no LDAC pulse is issued.

## Configuration
- DAC_OFFSET_BINARY_EN
  - Defined: the MSB of the sample is inverted when loading the shift register, converting two's complement to offset binary (0x000000 → 0x800000).
  - Undefined: the sample is shifted unmodified.
- The holding register always stores the unmodified sample; conversion happens only at the shift-register load.

## Test plan
- Single frame, SCLK_HALF=2, sample 0xA5C3F0, macro undefined:
  - 24 bits sampled on sclk rising edges equal 0xA5C3F0 MSB-first.
  - sync_n is low for exactly 98 cycles; ldac_n pulse is 2 cycles wide.
  - overrun stays 0.
- Same stimulus with DAC_OFFSET_BINARY_EN defined → shifted word is 0x25C3F0.
- Two strobes 10 cycles apart → second frame starts 1 cycle after busy falls, carries the second sample, overrun=0.
- Three strobes at cycles 0, 10, 20 → third sample dropped; overrun=1 from the edge after cycle 20. Only two frames are sent, with the first and second samples.
- Sample strobe coincident with the IDLE→LEAD load cycle → new sample held, no overrun, sent as the next frame.
- reset asserted 30 cycles into a frame:
  - Next edge: sync_n=1, sclk=0, ldac_n=1, busy=0, hold cleared.
  - After reset is released with no strobe, all outputs stay idle.
- overrun_clr and a new overrun event in the same cycle → overrun remains 1.

Source files
------------

// File: rtl/dac_spi_serializer.sv
// Serial DAC output stage: one-entry sample hold, MSB-first SPI frame, then an LDAC pulse.
// Optional macro DAC_OFFSET_BINARY_EN: invert the sample MSB at shift-register load (offset binary).
module dac_spi_serializer #(
  parameter int DATA_W    = 24,
  parameter int SCLK_HALF = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              overrun_clr,
  output logic              sclk,
  output logic              sync_n,
  output logic              sdo,
  output logic              ldac_n,
  output logic              busy,
  output logic              overrun
);

  localparam int PH_W  = (SCLK_HALF > 1) ? $clog2(SCLK_HALF) : 1;
  localparam int BIT_W = $clog2(DATA_W + 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SCLK_HALF - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W);

  typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, LOAD} state_t;

  state_t                   state, state_nx;
  logic [PH_W-1:0]          phase, phase_nx;
  logic [BIT_W-1:0]         bit_cnt, bit_cnt_nx;
  logic signed [DATA_W-1:0] hold_data;
  logic signed [DATA_W-1:0] shreg, shreg_nx;
  logic                     hold_valid;
  logic                     consume;
  logic                     take_sample;
  logic                     ovr_evt;
  logic                     phase_end;
  logic                     sclk_nx;
  logic                     sdo_nx;

  function automatic logic signed [DATA_W-1:0] to_dac_code(input logic signed [DATA_W-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
    to_dac_code = $signed({~s[DATA_W-1], s[DATA_W-2:0]});
`else
    to_dac_code = s;
`endif
  endfunction

  // Hold entry is consumed on the IDLE edge that launches a frame; a strobe on that
  // same edge refills it instead of counting as an overrun.
  assign consume     = (state == IDLE) && hold_valid;
  assign take_sample = sample_valid && (!hold_valid || consume);
  assign ovr_evt     = sample_valid && hold_valid && !consume;
  assign phase_end   = (phase == PH_LAST);

  always_comb begin
    state_nx   = state;
    phase_nx   = phase + 1'b1;
    bit_cnt_nx = bit_cnt;
    sclk_nx    = sclk;
    sdo_nx     = sdo;
    shreg_nx   = shreg;
    unique case (state)
      IDLE: begin
        phase_nx = '0;
        if (hold_valid) begin
          state_nx   = LEAD;
          shreg_nx   = to_dac_code(hold_data);
          sdo_nx     = shreg_nx[DATA_W-1];
          sclk_nx    = 1'b0;
          bit_cnt_nx = '0;
        end
      end
      LEAD: if (phase_end) begin
        state_nx   = SHIFT;
        phase_nx   = '0;
        bit_cnt_nx = '0;
        sclk_nx    = 1'b1;
      end
      // bit_cnt counts falling edges; the frame ends after the low phase of the last bit
      SHIFT: if (phase_end) begin
        phase_nx = '0;
        if (sclk) begin
          sclk_nx    = 1'b0;
          shreg_nx   = shreg <<< 1;
          sdo_nx     = shreg[DATA_W-2];
          bit_cnt_nx = bit_cnt + 1'b1;
        end else if (bit_cnt == BIT_LAST) begin
          state_nx   = TRAIL;
          sdo_nx     = 1'b0;
          bit_cnt_nx = '0;
        end else begin
          sclk_nx = 1'b1;
        end
      end
      TRAIL: if (phase_end) begin
        state_nx = LOAD;
        phase_nx = '0;
      end
      LOAD: if (phase_end) begin
        state_nx = IDLE;
        phase_nx = '0;
      end
      default: begin
        state_nx = IDLE;
        phase_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      phase   <= '0;
      bit_cnt <= '0;
      sclk    <= 1'b0;
      sdo     <= 1'b0;
      sync_n  <= 1'b1;
      ldac_n  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      phase   <= phase_nx;
      bit_cnt <= bit_cnt_nx;
      sclk    <= sclk_nx;
      sdo     <= sdo_nx;
      sync_n  <= !((state_nx == LEAD) || (state_nx == SHIFT));
      ldac_n  <= (state_nx != LOAD);
      busy    <= (state_nx != IDLE);
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_nx;
    if (take_sample) hold_data <= $signed(sample_in);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (take_sample)  hold_valid <= 1'b1;
      else if (consume) hold_valid <= 1'b0;
      if (ovr_evt)          overrun <= 1'b1;
      else if (overrun_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_spi_serializer.sv
// Bench for dac_spi_serializer: timeline model of frames plus directed and random strobes.
module tb_dac_spi_serializer;

  localparam int DW    = 24;
  localparam int SH    = 2;
  localparam int FRAME = (2 * DW + 3) * SH;
`ifdef DAC_OFFSET_BINARY_EN
  localparam logic [DW-1:0] EXP_FIRST = 24'h25C3F0;
`else
  localparam logic [DW-1:0] EXP_FIRST = 24'hA5C3F0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          sample_valid = 1'b0;
  logic [DW-1:0] sample_in = '0;
  logic          overrun_clr = 1'b0;
  logic          sclk, sync_n, sdo, ldac_n, busy, overrun;

  dac_spi_serializer #(.DATA_W(DW), .SCLK_HALF(SH)) dut (
    .clk(clk), .reset(reset), .sample_valid(sample_valid), .sample_in(sample_in),
    .overrun_clr(overrun_clr), .sclk(sclk), .sync_n(sync_n), .sdo(sdo),
    .ldac_n(ldac_n), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Behavioural model: which sample starts a frame on which edge; outputs follow from elapsed time.
  int            cyc = 0;
  bit            fr_act = 0;
  int            fr_start = 0;
  logic [DW-1:0] fr_word = '0;
  bit            m_hold_v = 0;
  logic [DW-1:0] m_hold_d = '0;
  bit            m_ovr = 0;

  function automatic logic [DW-1:0] conv(input logic [DW-1:0] s);
`ifdef DAC_OFFSET_BINARY_EN
    return s ^ (1 << (DW - 1));
`else
    return s;
`endif
  endfunction

  initial forever begin
    bit idle_before, take, ovr;
    @(posedge clk);
    cyc++;
    if (reset) begin
      m_hold_v = 0; m_ovr = 0; fr_act = 0;
    end else begin
      idle_before = !fr_act || (cyc - 1 >= fr_start + FRAME);
      take = idle_before && m_hold_v;
      ovr  = sample_valid && m_hold_v && !take;
      if (take) begin
        fr_act = 1; fr_start = cyc; fr_word = conv(m_hold_d); m_hold_v = 0;
      end
      if (sample_valid && !ovr) begin
        m_hold_d = sample_in; m_hold_v = 1;
      end
      if (ovr) m_ovr = 1;
      else if (overrun_clr) m_ovr = 0;
    end
  end

  initial forever begin
    int k, j, idx;
    logic e_sclk, e_sync, e_sdo, e_ldac, e_busy;
    @(negedge clk);
    if (chk_en) begin
      e_sclk = 0; e_sync = 1; e_sdo = 0; e_ldac = 1; e_busy = 0;
      k = cyc - fr_start;
      if (fr_act && k >= 0 && k < FRAME) begin
        e_busy = 1;
        if (k < SH) begin
          e_sync = 0; e_sdo = fr_word[DW-1];
        end else if (k < (2 * DW + 1) * SH) begin
          j = k - SH;
          e_sync = 0;
          e_sclk = ((j % (2 * SH)) < SH);
          idx = (j + SH) / (2 * SH);
          e_sdo = (idx < DW) ? fr_word[DW-1-idx] : 1'b0;
        end else if (k >= (2 * DW + 2) * SH) begin
          e_ldac = 0;
        end
      end
      chk("sclk", 32'(sclk), 32'(e_sclk));
      chk("sync_n", 32'(sync_n), 32'(e_sync));
      chk("sdo", 32'(sdo), 32'(e_sdo));
      chk("ldac_n", 32'(ldac_n), 32'(e_ldac));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("overrun", 32'(overrun), 32'(m_ovr));
    end
  end

  // DAC-side view: bits captured on sclk rising edges, run lengths of sync_n and ldac_n.
  logic [DW-1:0] got_words[$];
  logic [DW-1:0] cap_word = '0;
  int  nbits = 0, sync_run = 0, ldac_run = 0, last_sync_run = 0, last_ldac_run = 0;
  int  busy_fall_cyc = 0, last_gap = -1;
  logic p_sclk = 0, p_sync = 1, p_ldac = 1, p_busy = 0;

  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      if (sclk && !p_sclk) begin
        cap_word = {cap_word[DW-2:0], sdo};
        nbits++;
      end
      if (!sync_n && p_sync) begin
        nbits = 0; last_gap = cyc - busy_fall_cyc;
      end
      if (sync_n && !p_sync) begin
        last_sync_run = sync_run;
        if (nbits == DW) got_words.push_back(cap_word);
      end
      sync_run = sync_n ? 0 : sync_run + 1;
      if (ldac_n && !p_ldac) last_ldac_run = ldac_run;
      ldac_run = ldac_n ? 0 : ldac_run + 1;
      if (!busy && p_busy) busy_fall_cyc = cyc;
    end
    p_sclk = sclk; p_sync = sync_n; p_ldac = ldac_n; p_busy = busy;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [DW-1:0] d);
    sample_valid = 1; sample_in = d;
    @(negedge clk);
    sample_valid = 0;
  endtask

  initial begin
    logic [DW-1:0] a, b, c;
    tick(3);
    chk_en = 1;
    chk("rst_sync_n", 32'(sync_n), 32'd1);
    chk("rst_sclk", 32'(sclk), 32'd0);
    chk("rst_ldac_n", 32'(ldac_n), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    reset = 0;
    tick(2);

    // single frame
    strobe(24'hA5C3F0);
    tick(120);
    chk("single_count", 32'(got_words.size()), 32'd1);
    if (got_words.size() > 0) chk("single_word", 32'(got_words[0]), 32'(EXP_FIRST));
    chk("single_sync_len", 32'(last_sync_run), 32'd98);
    chk("single_ldac_len", 32'(last_ldac_run), 32'd2);
    chk("single_overrun", 32'(overrun), 32'd0);
    got_words.delete();

    // two strobes 10 cycles apart
    a = 24'h123456; b = 24'hFEDCBA;
    strobe(a); tick(9); strobe(b);
    tick(230);
    chk("two_count", 32'(got_words.size()), 32'd2);
    if (got_words.size() == 2) begin
      chk("two_w0", 32'(got_words[0]), 32'(conv(a)));
      chk("two_w1", 32'(got_words[1]), 32'(conv(b)));
    end
    chk("two_gap", 32'(last_gap), 32'd1);
    chk("two_overrun", 32'(overrun), 32'd0);
    got_words.delete();

    // three strobes: third dropped
    a = 24'h000001; b = 24'h7FFFFF; c = 24'h800000;
    strobe(a); tick(9); strobe(b); tick(9); strobe(c);
    chk("three_ovr_set", 32'(overrun), 32'd1);
    tick(230);
    chk("three_count", 32'(got_words.size()), 32'd2);
    if (got_words.size() == 2) begin
      chk("three_w0", 32'(got_words[0]), 32'(conv(a)));
      chk("three_w1", 32'(got_words[1]), 32'(conv(b)));
    end
    overrun_clr = 1; tick(1); overrun_clr = 0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    got_words.delete();

    // strobe on the load edge
    a = 24'h0F0F0F; b = 24'hF0F0F0;
    sample_valid = 1; sample_in = a; tick(1);
    sample_in = b; tick(1);
    sample_valid = 0;
    chk("coinc_overrun", 32'(overrun), 32'd0);
    tick(230);
    chk("coinc_count", 32'(got_words.size()), 32'd2);
    if (got_words.size() == 2) begin
      chk("coinc_w0", 32'(got_words[0]), 32'(conv(a)));
      chk("coinc_w1", 32'(got_words[1]), 32'(conv(b)));
    end
    chk("coinc_gap", 32'(last_gap), 32'd1);
    got_words.delete();

    // reset mid-frame, with a pending entry that must be discarded
    strobe(24'h55AA55); tick(9); strobe(24'h333333); tick(19);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    reset = 1; tick(1);
    chk("midrst_sync_n", 32'(sync_n), 32'd1);
    chk("midrst_sclk", 32'(sclk), 32'd0);
    chk("midrst_ldac_n", 32'(ldac_n), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    reset = 0;
    tick(150);
    chk("midrst_no_frame", 32'(got_words.size()), 32'd0);
    chk("midrst_idle", 32'(busy), 32'd0);

    // clear and set in the same cycle
    strobe(24'h111111); tick(4); strobe(24'h222222); tick(4);
    overrun_clr = 1; strobe(24'h444444); overrun_clr = 0;
    chk("clr_vs_set", 32'(overrun), 32'd1);
    tick(230);
    overrun_clr = 1; tick(1); overrun_clr = 0;
    chk("clr_after", 32'(overrun), 32'd0);
    got_words.delete();

    // random traffic
    for (int i = 0; i < 4000; i++) begin
      sample_valid = ($urandom_range(0, 99) < 2);
      sample_in    = DW'($urandom);
      overrun_clr  = ($urandom_range(0, 99) < 1);
      reset        = ($urandom_range(0, 999) < 1);
      tick(1);
    end
    sample_valid = 0; overrun_clr = 0; reset = 0;
    tick(FRAME + 10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
